// File: rtl/wb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_sdram_arbiter
// Purpose  : Two-master Wishbone B3 arbiter in front of the single SDRAM
//            controller slave port. m0 (LCD line fetch) has fixed priority
//            over m1 (CPU data), but a streak counter stops m0 from starving
//            m1. A grant is held for a whole bus cycle so bursts are never
//            split. A watchdog aborts transfers the slave never acknowledges.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            m0_* / m1_*           - Wishbone master-side ports (cyc, stb,
//                                    we, adr, dat_w, sel in; dat_r, ack,
//                                    err out)
//            s_*                   - Wishbone slave-side port to the SDRAM
//                                    controller
//            gnt                   - one-hot owner (bit0 = m0)
//            timeout_flag          - sticky abort indicator, cleared by rst
// Revision : 1.0 - initial release
// ============================================================================
module wb_sdram_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (LCD line fetch, high priority)
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  output logic [DW-1:0]   m0_dat_r,
  output logic            m0_ack,
  output logic            m0_err,
  // master 1 (processor data)
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  output logic [DW-1:0]   m1_dat_r,
  output logic            m1_ack,
  output logic            m1_err,
  // slave port (SDRAM controller)
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack,
  // status
  output logic [1:0]      gnt,
  output logic            timeout_flag
);

  localparam logic [2:0] c_streak_max = 3'(MAX_STREAK);
  localparam logic [7:0] c_timeout    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [2:0]  streak_q, streak_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        timeout_flag_q, timeout_flag_d;

  // Signals of whichever master currently owns the slave port.
  logic            owning;
  logic            own_m1;
  logic            sel_cyc;
  logic            sel_stb;
  logic            sel_we;
  logic [AW-1:0]   sel_adr;
  logic [DW-1:0]   sel_dat_w;
  logic [DW/8-1:0] sel_sel;

  // cyc of the master recorded in gnt; used while draining an aborted cycle.
  logic            held_cyc;
  // Watchdog expiry this cycle. An ack in the same cycle or a release by the
  // owner both take precedence, so neither may coincide with an abort.
  logic            expire;

  // --------------------------------------------------------------------------
  // Owner selection
  // --------------------------------------------------------------------------
  always_comb begin : owner_mux
    owning = (state_q == OWN0) || (state_q == OWN1);
    own_m1 = (state_q == OWN1);
    if (own_m1) begin
      sel_cyc   = m1_cyc;
      sel_stb   = m1_stb;
      sel_we    = m1_we;
      sel_adr   = m1_adr;
      sel_dat_w = m1_dat_w;
      sel_sel   = m1_sel;
    end else begin
      sel_cyc   = m0_cyc;
      sel_stb   = m0_stb;
      sel_we    = m0_we;
      sel_adr   = m0_adr;
      sel_dat_w = m0_dat_w;
      sel_sel   = m0_sel;
    end
  end

  assign held_cyc = gnt_q[1] ? m1_cyc : m0_cyc;
  assign expire   = owning && sel_cyc && !s_ack && (wdog_q == c_timeout);

  // --------------------------------------------------------------------------
  // Slave-side drive: the owner passes straight through, everything else is
  // parked at zero so IDLE and DRAIN present an idle bus.
  // --------------------------------------------------------------------------
  always_comb begin : slave_drive
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    if (owning) begin
      s_cyc   = sel_cyc;
      s_stb   = sel_stb;
      s_we    = sel_we;
      s_adr   = sel_adr;
      s_dat_w = sel_dat_w;
      s_sel   = sel_sel;
    end
  end

  // --------------------------------------------------------------------------
  // Master-side responses. Read data is broadcast; only the owner sees ack.
  // A stale ack outside an ownership state is dropped. While rst is high the
  // interrupted cycle must not complete, so ack/err are masked.
  // --------------------------------------------------------------------------
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  always_comb begin : master_resp
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    m0_err = 1'b0;
    m1_err = 1'b0;
    if (!rst) begin
      m0_ack = (state_q == OWN0) && s_ack;
      m1_ack = (state_q == OWN1) && s_ack;
      m0_err = (state_q == OWN0) && expire;
      m1_err = (state_q == OWN1) && expire;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin : next_state
    state_d        = state_q;
    gnt_d          = gnt_q;
    streak_d       = streak_q;
    wdog_d         = wdog_q;
    timeout_flag_d = timeout_flag_q;

    case (state_q)
      IDLE: begin
        gnt_d  = 2'b00;
        // Watchdog starts every ownership from zero.
        wdog_d = 8'd0;
        if (m0_cyc && (!m1_cyc || (streak_q != c_streak_max))) begin
          state_d = OWN0;
          gnt_d   = 2'b01;
          // Only m0 grants taken at m1's expense count toward the streak.
          if (m1_cyc) begin
            streak_d = (streak_q == c_streak_max) ? streak_q : streak_q + 3'd1;
          end else begin
            streak_d = 3'd0;
          end
        end else if (m1_cyc) begin
          state_d  = OWN1;
          gnt_d    = 2'b10;
          streak_d = 3'd0;
        end
      end

      OWN0, OWN1: begin
        if (!sel_cyc) begin
          // End of bus cycle; one IDLE cycle always separates owners.
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else if (s_ack) begin
          wdog_d = 8'd0;
        end else if (expire) begin
          state_d        = DRAIN;
          timeout_flag_d = 1'b1;
        end else if (sel_stb && (wdog_q != 8'hFF)) begin
          // Gaps in stb between burst beats do not count as waiting.
          wdog_d = wdog_q + 8'd1;
        end
      end

      DRAIN: begin
        // Keep the aborted owner off the bus until it ends its cycle.
        if (!held_cyc) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q        <= IDLE;
      gnt_q          <= 2'b00;
      streak_q       <= 3'd0;
      wdog_q         <= 8'd0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      streak_q       <= streak_d;
      wdog_q         <= wdog_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign gnt          = gnt_q;
  assign timeout_flag = timeout_flag_q;

endmodule
`default_nettype wire
